// File: rtl/audio_rx_pkg.sv
// audio_rx_pkg: shared types and constants for the I2S ADC receiver.
//   rx_state_e     receiver framing state
//   SampleWDefault default output sample width
//   SlotWDefault   default bits per channel slot
//   ErrCntW        width of the optional framing-error counter
package audio_rx_pkg;

  typedef enum logic [1:0] {
    StWaitSync = 2'd0,
    StFirst    = 2'd1,
    StRun      = 2'd2
  } rx_state_e;

  localparam int unsigned SampleWDefault = 16;
  localparam int unsigned SlotWDefault   = 32;
  localparam int unsigned ErrCntW        = 8;

endpackage

// File: rtl/audio_i2s_rx_if.sv
// audio_i2s_rx_if: PCM output bundle from the I2S receiver to the mixer.
//   sample_l / sample_r  last complete left/right samples (MSB aligned)
//   sample_valid         one-cycle strobe when both samples update
//   locked               receiver has framed a good L/R pair
//   err_count            framing-error count (only with AUDIO_I2S_RX_ERRCNT_EN)
// master: driven by the receiver; slave: consumer side.
interface audio_i2s_rx_if
  import audio_rx_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SampleWDefault
);

  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                locked;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
  logic [ErrCntW-1:0]  err_count;

  modport master (output sample_l, output sample_r, output sample_valid, output locked,
                  output err_count);
  modport slave  (input sample_l, input sample_r, input sample_valid, input locked,
                  input err_count);
`else
  modport master (output sample_l, output sample_r, output sample_valid, output locked);
  modport slave  (input sample_l, input sample_r, input sample_valid, input locked);
`endif

endinterface

// File: rtl/audio_sync_edge.sv
// audio_sync_edge: N-stage synchroniser for an asynchronous input plus a
// rising-edge detector on the synchronised value.
//   clk_i   sampling clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   rise_o  one-cycle strobe on a synchronised 0->1 transition
module audio_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    dly_d  = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rise_o = sync_q[Stages-1] & ~dly_q;

endmodule

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx: I2S ADC receiver running in the clk_74a domain. bclk, lrck and
// adc are oversampled through matched synchronisers; data is taken on bclk
// rising edges, framed by LRCK changes, and delivered as MSB-aligned L/R pairs.
//   clk_74a       core clock (must be >= 4x bclk)
//   reset_l_main  asynchronous active-low reset
//   i2s_bclk      serial bit clock (asynchronous)
//   i2s_lrck      word select, 0 = left, 1 = right
//   i2s_adc       serial data, MSB first, one-bit I2S delay
//   pcm           audio_i2s_rx_if master: samples, valid strobe, locked
// Optional: define AUDIO_I2S_RX_ERRCNT_EN to add the saturating err_count output.
module audio_i2s_rx
  import audio_rx_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SampleWDefault,
  parameter int unsigned SLOT_W      = SlotWDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_74a,
  input  logic            reset_l_main,
  input  logic            i2s_bclk,
  input  logic            i2s_lrck,
  input  logic            i2s_adc,
  audio_i2s_rx_if.master  pcm
);

  localparam int unsigned CntW = $clog2(SLOT_W + 1);
  localparam logic [CntW-1:0] SlotMax = CntW'(SLOT_W);

  // Input conditioning; lrck/adc chains match the bclk depth so all stay aligned.
  logic rise;
  logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d, ad_sync_q, ad_sync_d;
  logic lr, d, chg;

  audio_sync_edge #(
    .Stages (SYNC_STAGES)
  ) u_bclk_sync (
    .clk_i  (clk_74a),
    .rst_ni (reset_l_main),
    .d_i    (i2s_bclk),
    .rise_o (rise)
  );

  always_comb begin
    lr_sync_d = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrck};
    ad_sync_d = {ad_sync_q[SYNC_STAGES-2:0], i2s_adc};
  end

  assign lr = lr_sync_q[SYNC_STAGES-1];
  assign d  = ad_sync_q[SYNC_STAGES-1];

  // Framing state and datapath registers.
  rx_state_e           state_q, state_d;
  logic                lr_prev_q, lr_prev_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d, shreg_w;
  logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
  logic                left_ok_q, left_ok_d;
  logic [SAMPLE_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                valid_q, valid_d, locked_q, locked_d;
  logic                slot_good;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
  logic [ErrCntW-1:0]  err_cnt_q, err_cnt_d;
`endif

  assign chg       = lr ^ lr_prev_q;
  assign slot_good = (bit_cnt_q == SlotMax - CntW'(1));

  // State register.
  always_ff @(posedge clk_74a or negedge reset_l_main) begin
    if (!reset_l_main) begin
      state_q <= StWaitSync;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each LRCK change advances alignment until RUN.
  always_comb begin
    state_d = state_q;
    if (rise && chg) begin
      unique case (state_q)
        StWaitSync: state_d = StFirst;
        StFirst:    state_d = StRun;
        StRun:      state_d = StRun;
        default:    state_d = StWaitSync;
      endcase
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    lr_prev_d   = lr_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif

    // Shift register with the current bit placed; bits past SAMPLE_W are dropped.
    shreg_w = shreg_q;
    for (int unsigned i = 0; i < SAMPLE_W; i++) begin
      if (32'(bit_cnt_q) == SAMPLE_W - 1 - i) shreg_w[i] = d;
    end

    if (rise) begin
      lr_prev_d = lr;
      if (state_q == StWaitSync) begin
        if (chg) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end else if (!chg) begin
        shreg_d = shreg_w;
        if (bit_cnt_q != SlotMax) bit_cnt_d = bit_cnt_q + CntW'(1);
      end else begin
        // The bit on an LRCK change closes the outgoing slot.
        shreg_d   = '0;
        bit_cnt_d = '0;
        if (state_q == StRun) begin
          if (!slot_good) begin
            locked_d  = 1'b0;
            left_ok_d = 1'b0;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrCntW'(1);
`endif
          end else if (!lr_prev_q) begin
            left_hold_d = shreg_w;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            sample_l_d = left_hold_q;
            sample_r_d = shreg_w;
            valid_d    = 1'b1;
            locked_d   = 1'b1;
            left_ok_d  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_74a or negedge reset_l_main) begin
    if (!reset_l_main) begin
      lr_sync_q   <= '0;
      ad_sync_q   <= '0;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      lr_sync_q   <= lr_sync_d;
      ad_sync_q   <= ad_sync_d;
      lr_prev_q   <= lr_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      sample_l_q  <= sample_l_d;
      sample_r_q  <= sample_r_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign pcm.sample_l     = sample_l_q;
  assign pcm.sample_r     = sample_r_q;
  assign pcm.sample_valid = valid_q;
  assign pcm.locked       = locked_q;
`ifdef AUDIO_I2S_RX_ERRCNT_EN
  assign pcm.err_count    = err_cnt_q;
`endif

endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb_audio_i2s_rx: directed bench for audio_i2s_rx. Drives an I2S stream into a
// 32-bit-slot instance and a 12-bit-slot instance sharing the same pins.
`timescale 1ns/1ps
module tb_audio_i2s_rx;

  localparam realtime ClkHalf  = 6.734;   // ~74.25 MHz
  localparam realtime BclkHalf = 162.76;  // ~3.072 MHz

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk = 1'b0, lrck = 1'b0, adc = 1'b0;
  logic carry = 1'b0;
  logic cur_ch = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0, dbl_cnt = 0, p12_cnt = 0, dbl12_cnt = 0, p12_before = 0;
  logic vprev = 1'b0, vprev12 = 1'b0;

  audio_i2s_rx_if #(.SAMPLE_W(16)) pcm ();
  audio_i2s_rx_if #(.SAMPLE_W(16)) pcm12 ();

  audio_i2s_rx #(
    .SAMPLE_W    (16),
    .SLOT_W      (32),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk_74a      (clk),
    .reset_l_main (rst_n),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_adc      (adc),
    .pcm          (pcm)
  );

  audio_i2s_rx #(
    .SAMPLE_W    (16),
    .SLOT_W      (12),
    .SYNC_STAGES (2)
  ) u_dut12 (
    .clk_74a      (clk),
    .reset_l_main (rst_n),
    .i2s_bclk     (bclk),
    .i2s_lrck     (lrck),
    .i2s_adc      (adc),
    .pcm          (pcm12)
  );

  initial forever #(ClkHalf) clk = ~clk;

  // Pulse counters; a high level on two consecutive cycles counts as a double.
  always @(negedge clk) begin
    if (pcm.sample_valid) pulse_cnt++;
    if (pcm.sample_valid && vprev) dbl_cnt++;
    vprev = pcm.sample_valid;
    if (pcm12.sample_valid) p12_cnt++;
    if (pcm12.sample_valid && vprev12) dbl12_cnt++;
    vprev12 = pcm12.sample_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Bit j of a slot carrying word: MSB first, zero beyond 16 bits.
  function automatic logic slot_bit(input logic [15:0] w, input int j);
    logic [15:0] t;
    t = w;
    return (j < 16) ? t[15-j] : 1'b0;
  endfunction

  // Sends slot bit periods first..last-1. Period 0 carries the previous slot's
  // final bit (I2S one-bit delay); LRCK and data change on falling bclk.
  task automatic send_bits(input logic ch, input logic [15:0] word, input int len,
                           input int first, input int last);
    for (int i = first; i < last; i++) begin
      bclk = 1'b0;
      lrck = ch;
      adc  = (i == 0) ? carry : slot_bit(word, i - 1);
      #(BclkHalf);
      bclk = 1'b1;
      #(BclkHalf);
    end
    if (last == len) carry = slot_bit(word, len - 1);
    cur_ch = ch;
  endtask

  task automatic send_slot(input logic ch, input logic [15:0] word, input int len);
    send_bits(ch, word, len, 0, len);
  endtask

  initial begin
    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    check("rst_sample_l", 32'(pcm.sample_l), 32'h0);
    check("rst_sample_r", 32'(pcm.sample_r), 32'h0);
    check("rst_valid", 32'(pcm.sample_valid), 32'h0);
    check("rst_locked", 32'(pcm.locked), 32'h0);
`ifdef AUDIO_I2S_RX_ERRCNT_EN
    check("rst_err_count", 32'(pcm.err_count), 32'h0);
`endif
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Lock-up: WAIT_SYNC slot, FIRST slot, then good frames.
    send_slot(1'b0, 16'hA5C3, 32);
    send_slot(1'b1, 16'h1234, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    check("no_pulse_align", 32'(pulse_cnt), 32'd0);
    check("unlocked_align", 32'(pcm.locked), 32'h0);
    send_slot(1'b1, 16'h1234, 32);
    check("no_pulse_left_only", 32'(pulse_cnt), 32'd0);
    send_slot(1'b0, 16'hA5C3, 32);
    check("pulse1_cnt", 32'(pulse_cnt), 32'd1);
    check("pulse1_locked", 32'(pcm.locked), 32'h1);
    check("pulse1_l", 32'(pcm.sample_l), 32'hA5C3);
    check("pulse1_r", 32'(pcm.sample_r), 32'h1234);
    send_slot(1'b1, 16'h1234, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    check("pulse2_cnt", 32'(pulse_cnt), 32'd2);
    send_slot(1'b1, 16'h1234, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    check("pulse3_cnt", 32'(pulse_cnt), 32'd3);
    check("pulse3_l", 32'(pcm.sample_l), 32'hA5C3);
    check("pulse3_r", 32'(pcm.sample_r), 32'h1234);

    // Short right slot -> framing error, then a fresh pair re-locks.
    send_slot(1'b1, 16'h1234, 31);
    send_slot(1'b0, 16'h0F0F, 32);
    check("err_unlocked", 32'(pcm.locked), 32'h0);
    check("err_no_pulse", 32'(pulse_cnt), 32'd3);
`ifdef AUDIO_I2S_RX_ERRCNT_EN
    check("err_count_1", 32'(pcm.err_count), 32'd1);
`endif
    send_slot(1'b1, 16'hF00F, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    check("relock_cnt", 32'(pulse_cnt), 32'd4);
    check("relock_locked", 32'(pcm.locked), 32'h1);
    check("relock_l", 32'(pcm.sample_l), 32'h0F0F);
    check("relock_r", 32'(pcm.sample_r), 32'hF00F);

    // Reset after 10 bits of a left slot.
    send_slot(1'b1, 16'h1234, 32);
    send_bits(1'b0, 16'hA5C3, 32, 0, 10);
    check("pre_rst_cnt", 32'(pulse_cnt), 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_l", 32'(pcm.sample_l), 32'h0);
    check("midrst_r", 32'(pcm.sample_r), 32'h0);
    check("midrst_locked", 32'(pcm.locked), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_bits(1'b0, 16'hA5C3, 32, 10, 32);
    send_slot(1'b1, 16'h1234, 32);
    send_slot(1'b0, 16'hA5C3, 32);
    send_slot(1'b1, 16'h1234, 32);
    check("postrst_no_pulse", 32'(pulse_cnt), 32'd5);
    check("postrst_unlocked", 32'(pcm.locked), 32'h0);
    send_slot(1'b0, 16'hA5C3, 32);
    check("postrst_cnt", 32'(pulse_cnt), 32'd6);
    check("postrst_l", 32'(pcm.sample_l), 32'hA5C3);
    check("postrst_r", 32'(pcm.sample_r), 32'h1234);

    // bclk stopped: everything holds, no pulses.
    bclk = 1'b1;
    #(100_000.0);
    check("stop_cnt", 32'(pulse_cnt), 32'd6);
    check("stop_locked", 32'(pcm.locked), 32'h1);
    check("stop_l", 32'(pcm.sample_l), 32'hA5C3);
    check("stop_r", 32'(pcm.sample_r), 32'h1234);
    send_slot(1'b1, 16'h7FFE, 32);
    send_slot(1'b0, 16'h8001, 32);
    check("restart_cnt1", 32'(pulse_cnt), 32'd7);
    check("restart_r1", 32'(pcm.sample_r), 32'h7FFE);
    send_slot(1'b1, 16'h7FFE, 32);
    send_slot(1'b0, 16'h8001, 32);
    check("restart_cnt2", 32'(pulse_cnt), 32'd8);
    check("restart_l2", 32'(pcm.sample_l), 32'h8001);
    check("restart_locked", 32'(pcm.locked), 32'h1);

`ifdef AUDIO_I2S_RX_ERRCNT_EN
    // Long run of 2-bit slots saturates the error counter.
    for (int k = 0; k < 300; k++) send_slot(~cur_ch, 16'h0000, 2);
    check("err_count_sat", 32'(pcm.err_count), 32'hFF);
    check("err_sat_unlocked", 32'(pcm.locked), 32'h0);
`endif

    // 12-bit slots into the SLOT_W=12 instance.
    p12_before = p12_cnt;
    for (int k = 0; k < 6; k++) begin
      if (cur_ch) send_slot(1'b0, 16'hFFF0, 12);
      else        send_slot(1'b1, 16'hABC0, 12);
    end
    check("s12_pulsed", 32'(p12_cnt > p12_before), 32'h1);
    check("s12_l", 32'(pcm12.sample_l), 32'hFFF0);
    check("s12_r", 32'(pcm12.sample_r), 32'hABC0);
    check("s12_locked", 32'(pcm12.locked), 32'h1);

    check("valid_one_cycle", 32'(dbl_cnt), 32'd0);
    check("valid12_one_cycle", 32'(dbl12_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
